acc_drain: RTL and testbench

ACC_DRAIN -- requirements
Module: acc_drain

---
 rtl/acc_drain.sv | 187 ++++++++++++++++++
 tb/tb_acc_drain.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/acc_drain.sv
// acc_drain: captures a vector of NUM_ACC signed accumulator lanes.
// The lanes are then drained one word per handshake on a valid/ready stream.
// Each word is arithmetically shifted right by RSHIFT and narrowed to OUT_WIDTH.
// A new vector may be accepted on the last-beat handshake, so there is no bubble
// between vectors.
// Optional feature macro: ACC_DRAIN_SAT_EN
//   defined   -> saturate to the OUT_WIDTH signed range and flag the word on out_sat
//   undefined -> two's-complement wrap (low OUT_WIDTH bits), out_sat tied low
module acc_drain #(
    parameter int NUM_ACC   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int RSHIFT    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [NUM_ACC*IN_WIDTH-1:0]   load_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_ACC)-1:0]    out_index,
    output logic                          out_last,
    output logic                          out_sat
);

    localparam int IDX_W = $clog2(NUM_ACC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACC - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Shift, then narrow one lane; returns {sat_flag, word}.
    function automatic logic [OUT_WIDTH:0] narrow_lane(input logic signed [IN_WIDTH-1:0] lane);
        logic signed [IN_WIDTH-1:0] shifted;
`ifdef ACC_DRAIN_SAT_EN
        logic signed [IN_WIDTH-1:0] sat_max;
        logic signed [IN_WIDTH-1:0] sat_min;
`endif
        shifted = lane >>> RSHIFT;
`ifdef ACC_DRAIN_SAT_EN
        sat_max = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        sat_min = {{(IN_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
        if (shifted > sat_max) begin
            narrow_lane = {1'b1, sat_max[OUT_WIDTH-1:0]};
        end else if (shifted < sat_min) begin
            narrow_lane = {1'b1, sat_min[OUT_WIDTH-1:0]};
        end else begin
            narrow_lane = {1'b0, shifted[OUT_WIDTH-1:0]};
        end
`else
        narrow_lane = {1'b0, shifted[OUT_WIDTH-1:0]};
`endif
    endfunction

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_index;
    logic [IDX_W-1:0]              w_index_nxt;
    logic [NUM_ACC*IN_WIDTH-1:0]   r_lanes;
    logic [NUM_ACC*IN_WIDTH-1:0]   w_lanes_nxt;
    logic signed [IN_WIDTH-1:0]    w_lane_sel;
    logic [OUT_WIDTH:0]            w_narrowed;
    logic                          w_load_ready;
    logic                          w_out_valid;
    logic                          w_load_fire;
    logic                          w_out_fire;
    logic [OUT_WIDTH-1:0]          r_out_data;
    logic [IDX_W-1:0]              r_out_index;
    logic                          r_out_last;
    logic                          r_out_sat;

    // State register: reset returns to IDLE at index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
        end
    end

    // Next-state logic: advance the index on each accepted word and reload on the last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        case (r_state)
            ST_IDLE: begin
                if (w_load_fire) begin
                    w_state_nxt = ST_DRAIN;
                    w_index_nxt = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (w_out_fire) begin
                    if (r_index == LAST_IDX) begin
                        w_state_nxt = w_load_fire ? ST_DRAIN : ST_IDLE;
                        w_index_nxt = '0;
                    end else begin
                        w_index_nxt = r_index + IDX_W'(1);
                    end
                end else begin
                    w_index_nxt = r_index;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_index_nxt = '0;
            end
        endcase
    end

    // Handshake outputs: ready in IDLE or on the last-beat handshake; valid while draining.
    always_comb begin
        w_out_valid  = 1'b0;
        w_load_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_out_valid  = 1'b0;
                w_load_ready = 1'b1;
            end
            ST_DRAIN: begin
                w_out_valid  = 1'b1;
                w_load_ready = out_ready && (r_index == LAST_IDX);
            end
            default: begin
                w_out_valid  = 1'b0;
                w_load_ready = 1'b0;
            end
        endcase
    end

    assign w_load_fire = load_valid && w_load_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    // Lane select for the word to be presented next cycle (new vector if one is being taken).
    always_comb begin
        w_lanes_nxt = w_load_fire ? load_data : r_lanes;
        w_lane_sel  = w_lanes_nxt[int'(w_index_nxt)*IN_WIDTH +: IN_WIDTH];
        w_narrowed  = narrow_lane(w_lane_sel);
    end

    // Captured lanes: written only when a load is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lanes <= '0;
        end else if (w_load_fire) begin
            r_lanes <= load_data;
        end else begin
            r_lanes <= r_lanes;
        end
    end

    // Word outputs are registered so out_ready never reaches them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end else if (w_state_nxt == ST_DRAIN) begin
            r_out_data  <= w_narrowed[OUT_WIDTH-1:0];
            r_out_index <= w_index_nxt;
            r_out_last  <= (w_index_nxt == LAST_IDX);
            r_out_sat   <= w_narrowed[OUT_WIDTH];
        end else begin
            r_out_data  <= '0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_sat   <= 1'b0;
        end
    end

    assign load_ready = w_load_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = r_out_data;
    assign out_index  = r_out_index;
    assign out_last   = r_out_last;
    assign out_sat    = r_out_sat;

endmodule

// File: tb/tb_acc_drain.sv
// Directed self-checking bench for acc_drain (NUM_ACC=4, IN_WIDTH=32, OUT_WIDTH=16, RSHIFT=0).
// Expected narrowing results follow ACC_DRAIN_SAT_EN when it is defined for the build.
module tb_acc_drain;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [127:0]  load_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [1:0]    out_index;
    logic          out_last;
    logic          out_sat;

    int checks;
    int failures;

    acc_drain #(
        .NUM_ACC   (4),
        .IN_WIDTH  (32),
        .OUT_WIDTH (16),
        .RSHIFT    (0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_sat    (out_sat)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] d, input logic [1:0] idx,
                            input logic last, input logic sat);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".index"}, 32'(out_index), 32'(idx));
        chk({tag, ".last"},  32'(out_last),  32'(last));
        chk({tag, ".sat"},   32'(out_sat),   32'(sat));
    endtask

    logic        exp_sat01;
    logic [15:0] exp_w0;
    logic [15:0] exp_w1;

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = 128'd0;
        out_ready  = 1'b0;
`ifdef ACC_DRAIN_SAT_EN
        exp_w0    = 16'h7FFF;
        exp_w1    = 16'h8000;
        exp_sat01 = 1'b1;
`else
        exp_w0    = 16'h2345;
        exp_w1    = 16'hEE90;
        exp_sat01 = 1'b0;
`endif

        // Reset held for two cycles.
        tick();
        tick();
        chk("rst.valid", 32'(out_valid),  32'd0);
        chk("rst.ready", 32'(load_ready), 32'd1);
        chk("rst.data",  32'(out_data),   32'd0);
        chk("rst.index", 32'(out_index),  32'd0);
        chk("rst.last",  32'(out_last),   32'd0);
        chk("rst.sat",   32'(out_sat),    32'd0);
        reset = 1'b0;
        tick();
        chk("idle.valid", 32'(out_valid), 32'd0);

        // Plain drain of {1,2,3,4}.
        load_data  = {32'd4, 32'd3, 32'd2, 32'd1};
        load_valid = 1'b1;
        out_ready  = 1'b1;
        chk("drain.load_ready", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        chk_word("drain.w0", 16'd1, 2'd0, 1'b0, 1'b0);
        tick();
        chk_word("drain.w1", 16'd2, 2'd1, 1'b0, 1'b0);
        tick();
        chk_word("drain.w2", 16'd3, 2'd2, 1'b0, 1'b0);
        tick();
        chk_word("drain.w3", 16'd4, 2'd3, 1'b1, 1'b0);
        chk("drain.last_ready", 32'(load_ready), 32'd1);
        tick();
        chk("drain.idle_valid", 32'(out_valid),  32'd0);
        chk("drain.idle_ready", 32'(load_ready), 32'd1);

        // Backpressure at index 1; a load offered during the stall must be ignored.
        load_data  = {32'd4, 32'd3, 32'd2, 32'd1};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_word("bp.w0", 16'd1, 2'd0, 1'b0, 1'b0);
        tick();
        out_ready  = 1'b0;
        load_valid = 1'b1;
        load_data  = {32'd55, 32'd55, 32'd55, 32'd55};
        chk_word("bp.hold1", 16'd2, 2'd1, 1'b0, 1'b0);
        chk("bp.load_ready", 32'(load_ready), 32'd0);
        tick();
        chk_word("bp.hold2", 16'd2, 2'd1, 1'b0, 1'b0);
        tick();
        chk_word("bp.hold3", 16'd2, 2'd1, 1'b0, 1'b0);
        load_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        chk_word("bp.w2", 16'd3, 2'd2, 1'b0, 1'b0);
        tick();
        chk_word("bp.w3", 16'd4, 2'd3, 1'b1, 1'b0);
        tick();
        chk("bp.idle_valid", 32'(out_valid), 32'd0);

        // Narrowing boundaries, then back-to-back load on the last beat.
        load_data  = {32'h00007FFF, 32'hFFFF8000, 32'hFFFEEE90, 32'h00012345};
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk_word("nar.w0", exp_w0, 2'd0, 1'b0, exp_sat01);
        tick();
        chk_word("nar.w1", exp_w1, 2'd1, 1'b0, exp_sat01);
        tick();
        chk_word("nar.w2", 16'h8000, 2'd2, 1'b0, 1'b0);
        tick();
        chk_word("nar.w3", 16'h7FFF, 2'd3, 1'b1, 1'b0);
        load_data  = {32'd6, 32'd7, 32'd8, 32'd9};
        load_valid = 1'b1;
        chk("b2b.load_ready", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        chk_word("b2b.w0", 16'd9, 2'd0, 1'b0, 1'b0);
        tick();
        chk_word("b2b.w1", 16'd8, 2'd1, 1'b0, 1'b0);
        tick();
        chk_word("b2b.w2", 16'd7, 2'd2, 1'b0, 1'b0);

        // Reset mid-drain at index 2, with a load offered alongside.
        reset      = 1'b1;
        load_valid = 1'b1;
        tick();
        chk("mrst.valid", 32'(out_valid),  32'd0);
        chk("mrst.ready", 32'(load_ready), 32'd1);
        chk("mrst.data",  32'(out_data),   32'd0);
        chk("mrst.index", 32'(out_index),  32'd0);
        tick();
        chk("mrst.prio_valid", 32'(out_valid), 32'd0);
        reset      = 1'b0;
        load_valid = 1'b0;
        tick();
        chk("mrst.after1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("mrst.after2_valid", 32'(out_valid),  32'd0);
        chk("mrst.after2_ready", 32'(load_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
